// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, data width and baud divisor helper for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DATA_BITS = 8;
  function automatic int calc_divisor(input int clkfreq, input int baud, input int oversample);
    int d;
    d = clkfreq / (baud * oversample);
    return d < 1 ? 1 : d;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running baud divider, one-clk tick at terminal count, restartable
//   clk     in  system clock
//   reset   in  async active-low reset
//   restart in  clears the divider so the next tick is a full period away
//   tick    out one-clk pulse every DIVISOR clks
module uart_baud_gen import uart_pkg::*; #(
  parameter int CLKFREQ    = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int DIVISOR = calc_divisor(CLKFREQ, BAUD, OVERSAMPLE);
  localparam int W = DIVISOR > 1 ? $clog2(DIVISOR) : 1;
  logic [W-1:0] r_cnt;
  assign tick = r_cnt == W'(DIVISOR - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_cnt <= '0;
    else r_cnt <= (restart || tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_xmit.sv
// uart_xmit: 8N1 UART transmitter (8E1 when XMIT_PARITY_EN is defined), idle-high
//   clk      in  system clock
//   reset    in  async active-low reset
//   char     in  character, latched when a request is accepted
//   sendchar in  request; a rising edge while idle starts a frame
//   txpin    out registered serial line, 1 = mark
//   busy     out high while a frame is in progress
module uart_xmit import uart_pkg::*; #(
  parameter int CLKFREQ    = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char,
  input  logic       sendchar,
  output logic       txpin,
  output logic       busy
);
  localparam int OSW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
  localparam int CW  = $clog2(DATA_BITS);
  state_t               r_state;
  logic [DATA_BITS-1:0] r_sr;
  logic [CW-1:0]        r_cnt;
  logic [OSW-1:0]       r_os;
  logic                 r_send_q, r_txpin, r_busy;
  logic                 w_tick, w_accept, w_bit_end;
`ifdef XMIT_PARITY_EN
  logic                 r_par;
`endif
  assign w_accept  = sendchar && !r_send_q && r_state == IDLE;
  // a bit ends on the last of OVERSAMPLE ticks
  assign w_bit_end = w_tick && r_os == OSW'(OVERSAMPLE - 1);
  assign txpin     = r_txpin;
  assign busy      = r_busy;
  uart_baud_gen #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_baud (
    .clk(clk), .reset(reset), .restart(w_accept), .tick(w_tick)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_sr     <= '0;
      r_cnt    <= '0;
      r_os     <= '0;
      r_send_q <= 1'b0;
      r_txpin  <= 1'b1;
      r_busy   <= 1'b0;
`ifdef XMIT_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_send_q <= sendchar;
      if (r_state != IDLE && w_tick) r_os <= w_bit_end ? '0 : r_os + 1'b1;
      case (r_state)
        IDLE: if (w_accept) begin
          r_sr    <= char;
          r_cnt   <= '0;
          r_os    <= '0;
          r_state <= START;
          r_txpin <= 1'b0;
          r_busy  <= 1'b1;
`ifdef XMIT_PARITY_EN
          r_par   <= ^char;
`endif
        end
        START: if (w_bit_end) begin
          r_state <= DATA;
          r_txpin <= r_sr[0];
        end
        DATA: if (w_bit_end) begin
          if (r_cnt == CW'(DATA_BITS - 1)) begin
`ifdef XMIT_PARITY_EN
            r_state <= PARITY;
            r_txpin <= r_par;
`else
            r_state <= STOP;
            r_txpin <= 1'b1;
`endif
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_sr    <= r_sr >> 1;
            r_txpin <= r_sr[1];
          end
        end
`ifdef XMIT_PARITY_EN
        PARITY: if (w_bit_end) begin
          r_state <= STOP;
          r_txpin <= 1'b1;
        end
`endif
        STOP: if (w_bit_end) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_txpin <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_txpin <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_xmit.sv
// tb_uart_xmit: directed self-checking bench for uart_xmit at 12 MHz / 115200 baud
`timescale 1ns/1ps
module tb_uart_xmit;
  localparam int BIT = 104;
`ifdef XMIT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ch = 8'h00;
  logic       sendchar = 1'b0;
  logic       txpin, busy;
  int         n_vec = 0;
  int         n_err = 0;

  always #41.667 clk = ~clk;

  uart_xmit #(.CLKFREQ(12_000_000), .BAUD(115200), .OVERSAMPLE(1)) dut (
    .clk(clk), .reset(reset), .char(ch), .sendchar(sendchar), .txpin(txpin), .busy(busy)
  );

  task automatic check_quiet(input int cycles, input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || txpin !== 1'b1) bad++;
    end
    n_vec++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL %s: %0d cycles with busy/txpin not idle (got busy=%b txpin=%b, want 0/1)", nm, bad, busy, txpin);
    end
  endtask

  // starts a request and returns once busy is seen, ok=0 if it never rises
  task automatic start_req(input logic [7:0] c, input string nm, output bit ok);
    @(negedge clk);
    ch = c;
    sendchar = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b1) ok = 1;
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s start: busy=%b, want 1 within 10 clks", nm, busy);
    end
  endtask

  task automatic run_frame(input logic [7:0] c, input bit hold, input bit inject, input string nm);
    logic [10:0] bits;
    int n;
    bit ok;
    bits = 11'h7FF;
    bits[0] = 1'b0;
    bits[8:1] = c;
`ifdef XMIT_PARITY_EN
    bits[9] = ^c;
`endif
    start_req(c, nm, ok);
    if (!ok) return;
    n = 0;
    while (busy === 1'b1 && n < 1300) begin
      if (n % BIT == BIT / 2) begin
        n_vec++;
        if (txpin !== bits[n / BIT]) begin
          n_err++;
          $display("FAIL %s bit%0d: txpin=%b, want %b", nm, n / BIT, txpin, bits[n / BIT]);
        end
      end
      if (!hold && n == 4) sendchar = 1'b0;
      if (inject) begin
        if (n == 500) begin ch = 8'hFF; sendchar = 1'b1; end
        if (n == 520) sendchar = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    n_vec++;
    if (n !== NB * BIT) begin
      n_err++;
      $display("FAIL %s busy_len: %0d clks, want %0d", nm, n, NB * BIT);
    end
    check_quiet(300, {nm, " no_second_frame"});
    sendchar = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_vec++;
    if (txpin !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset: txpin=%b busy=%b, want 1/0", txpin, busy);
    end
    reset = 1'b1;
    check_quiet(1000, "idle_after_reset");
  endtask

  task automatic test_frame_55;
    run_frame(8'h55, 1'b1, 1'b0, "frame55_hold");
  endtask

  task automatic test_frame_41;
    check_quiet(1200, "gap_before_41");
    run_frame(8'h41, 1'b0, 1'b0, "frame41");
  endtask

  task automatic test_ignore_busy;
    run_frame(8'h3C, 1'b0, 1'b1, "ignore_mid_edge");
  endtask

  task automatic test_reset_mid;
    bit ok;
    start_req(8'hC6, "reset_mid", ok);
    if (ok) begin
      for (int i = 0; i < BIT / 2 + 4 * BIT; i++) begin
        if (i == 4) sendchar = 1'b0;
        @(negedge clk);
      end
      sendchar = 1'b0;
      #10 reset = 1'b0;
      #1;
      n_vec++;
      if (txpin !== 1'b1 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid async: txpin=%b busy=%b, want 1/0", txpin, busy);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      check_quiet(50, "after_mid_reset");
    end
    run_frame(8'hA3, 1'b0, 1'b0, "frame_after_reset");
  endtask

`ifdef XMIT_PARITY_EN
  task automatic test_parity;
    run_frame(8'h07, 1'b0, 1'b0, "parity07");
  endtask
`endif

  initial begin
    test_reset();
    test_frame_55();
    test_frame_41();
    test_ignore_busy();
    test_reset_mid();
`ifdef XMIT_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
